// File: rtl/config_chain_pkg.sv
// Shared types for the configuration-chain controller.
//   state_t : controller FSM states
//   mode_t  : operation selected by the 'mode' input
package config_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic {
    MODE_WRITE,
    MODE_READBACK
  } mode_t;

endpackage

// File: rtl/config_shift_chain.sv
// One pixel-array configuration shift chain.
// Shifts toward the MSB when enabled. The MSB is the serial output.
// Ports:
//   configClk   : chain clock
//   configRst   : synchronous active-high reset, clears the chain
//   configEn    : shift enable
//   configIn    : serial input, enters at bit 0
//   configOut   : serial output (bit NUM_BITS-1)
//   parallelOut : whole chain contents
module config_shift_chain #(
  parameter int NUM_BITS = 100
) (
  input  logic                configClk,
  input  logic                configRst,
  input  logic                configEn,
  input  logic                configIn,
  output logic                configOut,
  output logic [NUM_BITS-1:0] parallelOut
);

  logic [NUM_BITS-1:0] chain_reg;

  always_ff @(posedge configClk) begin
    if (configRst) begin
      chain_reg <= '0;
    end else if (configEn) begin
      chain_reg <= {chain_reg[NUM_BITS-2:0], configIn};
    end
  end

  assign configOut   = chain_reg[NUM_BITS-1];
  assign parallelOut = chain_reg;

endmodule

// File: rtl/config_chain_ctrl.sv
// Multi-array configuration-chain shift controller.
// Loads wr_data into the chain of array 'sel' (MSB first) while capturing
// the previous chain contents into rd_data. READBACK mode recirculates the
// chain output into its input so the chain is left unchanged.
// Ports:
//   configClk, configRst : clock, synchronous active-high reset
//   start, mode, sel     : op request (accepted in IDLE only)
//   wr_data              : word to load
//   rd_data              : previous chain contents of the last good op
//   busy, done, err      : status (err sticky until next accepted start)
//   configEn, configIn   : per-array shift enable / serial data
//   configOut            : per-array chain serial outputs
module config_chain_ctrl
  import config_chain_pkg::*;
#(
  parameter int NUM_BITS   = 100,
  parameter int NUM_ARRAYS = 8,
  parameter int SEL_W      = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1
) (
  input  logic                  configClk,
  input  logic                  configRst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_BITS-1:0]   wr_data,
  output logic [NUM_BITS-1:0]   rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NUM_ARRAYS-1:0] configEn,
  output logic [NUM_ARRAYS-1:0] configIn,
  input  logic [NUM_ARRAYS-1:0] configOut
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

  state_t                state_reg, state_next;
  mode_t                 mode_reg;
  logic [NUM_BITS-1:0]   sr_reg;
  logic [NUM_BITS-1:0]   cap_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [NUM_ARRAYS-1:0] en_reg;
  logic [NUM_ARRAYS-1:0] sel_onehot;
  logic                  sel_ok;
  logic                  accept;
  logic                  bad_start;
  logic                  last_shift;
  logic                  sel_out;

  // Decode sel; an out-of-range index decodes to all zeros.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_ARRAYS; i++) begin
      sel_onehot[i] = (int'(sel) == i);
    end
    sel_ok = (int'(sel) < NUM_ARRAYS);
  end

  // Serial output of the selected chain; en_reg is one-hot while shifting.
  assign sel_out = |(configOut & en_reg);

  always_ff @(posedge configClk) begin
    if (configRst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    bad_start  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    last_shift = (cnt_reg == LAST_CNT);
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            accept     = 1'b1;
            state_next = SHIFT;
          end else begin
            bad_start  = 1'b1;
            state_next = DONE;
          end
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge configClk) begin
    if (configRst) begin
      mode_reg <= MODE_WRITE;
      sr_reg   <= '0;
      cap_reg  <= '0;
      cnt_reg  <= '0;
      en_reg   <= '0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        mode_reg <= mode_t'(mode);
        sr_reg   <= wr_data;
        cnt_reg  <= '0;
        en_reg   <= sel_onehot;
        err      <= 1'b0;
      end else if (bad_start) begin
        err <= 1'b1;
      end
      if (state_reg == SHIFT) begin
        // configOut is sampled before this edge shifts the chain,
        // so cap collects the old contents MSB first.
        cap_reg <= {cap_reg[NUM_BITS-2:0], sel_out};
        sr_reg  <= sr_reg << 1;
        cnt_reg <= cnt_reg + 1'b1;
        if (last_shift) begin
          en_reg <= '0;
        end
      end
      if ((state_reg == DONE) && !err) begin
        rd_data <= cap_reg;
      end
    end
  end

  // Enable is a register. In READBACK the data input is the chain's own
  // output fed straight back, so each shift re-inserts the bit it pushes out.
  for (genvar gi = 0; gi < NUM_ARRAYS; gi++) begin : g_cfg_in
    assign configEn[gi] = en_reg[gi];
    assign configIn[gi] = en_reg[gi] &
                          ((mode_reg == MODE_READBACK) ? configOut[gi]
                                                       : sr_reg[NUM_BITS-1]);
  end

endmodule

// File: tb/tb_config_chain_ctrl.sv
// Self-checking bench for config_chain_ctrl driving four attached chains.
module tb_config_chain_ctrl;

  localparam int NB = 8;
  localparam int NA = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [SW-1:0] sel;
  logic [NB-1:0] wr_data;
  logic [NB-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [NA-1:0] en;
  logic [NA-1:0] cin;
  logic [NA-1:0] cout;
  logic [NB-1:0] par [NA];

  always #5 clk = ~clk;

  config_chain_ctrl #(
    .NUM_BITS  (NB),
    .NUM_ARRAYS(NA),
    .SEL_W     (SW)
  ) dut (
    .configClk(clk),
    .configRst(rst),
    .start    (start),
    .mode     (mode),
    .sel      (sel),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .configEn (en),
    .configIn (cin),
    .configOut(cout)
  );

  for (genvar gi = 0; gi < NA; gi++) begin : g_chain
    config_shift_chain #(.NUM_BITS(NB)) u_chain (
      .configClk  (clk),
      .configRst  (rst),
      .configEn   (en[gi]),
      .configIn   (cin[gi]),
      .configOut  (cout[gi]),
      .parallelOut(par[gi])
    );
  end

  // Enable pulses seen by each chain at active edges.
  int en_pulses [NA];
  always @(posedge clk) begin
    for (int i = 0; i < NA; i++) begin
      if (en[i] === 1'b1) en_pulses[i]++;
    end
  end

  // Reference model: what each chain holds, and the last readback word.
  logic [NB-1:0] m_chain [NA];
  logic [NB-1:0] m_rd;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < NA; i++) en_pulses[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from IDLE, checked against the model.
  task automatic run_op(input logic m, input int s, input logic [NB-1:0] d, input string tag);
    int            cyc;
    int            busy_cyc;
    bit            valid;
    logic [NB-1:0] exp_rd;
    valid  = (s < NA);
    exp_rd = valid ? m_chain[s] : m_rd;
    clear_pulses();
    start   = 1'b1;
    mode    = m;
    sel     = SW'(s);
    wr_data = d;
    step();
    start    = 1'b0;
    cyc      = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cyc++;
      step();
      cyc++;
    end
    check({tag, " done_cycle"}, cyc, valid ? NB + 1 : 1);
    check({tag, " busy_cycles"}, busy_cyc, valid ? NB : 0);
    check({tag, " err"}, {31'd0, err}, {31'd0, !valid});
    step();
    if (valid) begin
      if (m == 1'b0) m_chain[s] = d;
      m_rd = exp_rd;
    end
    check({tag, " rd_data"}, rd_data, m_rd);
    for (int i = 0; i < NA; i++) begin
      check({tag, $sformatf(" chain%0d", i)}, par[i], m_chain[i]);
      check({tag, $sformatf(" en_pulses%0d", i)}, en_pulses[i], (valid && i == s) ? NB : 0);
    end
    $display("op %s mode=%0d sel=%0d wr=%02h rd=%02h err=%0b", tag, m, s, d, rd_data, err);
  endtask

  initial begin
    int            ndone;
    int            first_done;
    int            second_done;
    logic [NB-1:0] d;

    rst     = 1'b1;
    start   = 1'b0;
    mode    = 1'b0;
    sel     = '0;
    wr_data = '0;
    clear_pulses();
    for (int i = 0; i < NA; i++) m_chain[i] = '0;
    m_rd = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset err", {31'd0, err}, 0);
    check("reset configEn", {28'd0, en}, 0);
    check("reset configIn", {28'd0, cin}, 0);
    check("reset rd_data", rd_data, 0);

    run_op(1'b0, 2, 8'hA5, "write_a5");
    run_op(1'b0, 2, 8'h3C, "write_3c");
    run_op(1'b1, 2, 8'h00, "readback");
    run_op(1'b0, 5, 8'h77, "bad_sel");

    // start held high: acceptances at edges 0 and 10 only.
    d = 8'h69;
    clear_pulses();
    start = 1'b1; mode = 1'b0; sel = SW'(1); wr_data = d;
    ndone = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) first_done = c;
        else if (ndone == 2) second_done = c;
      end
    end
    start = 1'b0;
    m_rd = d;
    m_chain[1] = d;
    check("held done_count", ndone, 2);
    check("held first_done", first_done, NB + 1);
    check("held second_done", second_done, 2 * NB + 3);
    check("held en_pulses", en_pulses[1], 2 * NB);
    check("held rd_data", rd_data, m_rd);
    check("held chain1", par[1], m_chain[1]);
    $display("op held_start done=%0d rd=%02h", ndone, rd_data);

    // Reset in SHIFT cycle 4 (chains share the reset, so they clear too).
    start = 1'b1; mode = 1'b0; sel = SW'(0); wr_data = 8'h5A;
    step();
    start = 1'b0;
    repeat (3) step();
    check("rst_mid busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NA; i++) m_chain[i] = '0;
    m_rd = '0;
    check("rst_mid busy", {31'd0, busy}, 0);
    check("rst_mid done", {31'd0, done}, 0);
    check("rst_mid configEn", {28'd0, en}, 0);
    check("rst_mid rd_data", rd_data, 0);
    $display("op reset_mid_shift busy=%0b en=%0h rd=%02h", busy, en, rd_data);
    run_op(1'b0, 0, 8'hFF, "post_rst");

    for (int k = 0; k < 24; k++) begin
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), NB'($urandom),
             $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
